// File: rtl/seq_generator.sv
// Serial frame transmitter: buffers one parallel word behind a valid/ready handshake
// and shifts it out MSB-first on dout/dout_vld, with an optional idle gap between frames.
module seq_generator #(
   parameter int WIDTH = 18,
   parameter int GAP   = 0,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_vld,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_rdy,
   output logic             dout,
   output logic             dout_vld,
   output logic             busy,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_cnt
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               dout_q, dout_d;
   logic               dout_vld_q, dout_vld_d;
   logic               frame_done_q, frame_done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               accept;
   logic               reload;

   assign load_rdy   = !hold_full_q && !rst;
   assign accept     = load_vld && load_rdy;

   assign dout       = dout_q;
   assign dout_vld   = dout_vld_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = cnt_q;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      hold_full_d  = hold_full_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      gap_d        = gap_q;
      cnt_d        = cnt_q;
      dout_d       = 1'b0;
      dout_vld_d   = 1'b0;
      frame_done_d = 1'b0;
      reload       = 1'b0;

      // accept and reload are exclusive: one needs the hold empty, the other full
      if (accept) begin
         hold_d      = load_data;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            reload = hold_full_q;
            if (!hold_full_q) state_d = S_IDLE;
         end
         S_SHIFT: begin
            dout_d     = shift_q[WIDTH-1];
            dout_vld_d = 1'b1;
            shift_d    = {shift_q[WIDTH-2:0], 1'b0};
            idx_d      = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               frame_done_d = 1'b1;
               cnt_d        = cnt_q + CNT_W'(1);
               if (GAP > 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_W'(GAP - 1);
               end else if (hold_full_q) begin
                  reload = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               if (hold_full_q) reload = 1'b1;
               else             state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (reload) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         idx_d       = '0;
         state_d     = S_SHIFT;
      end
   end

   assign busy_d = (state_d != S_IDLE) || hold_full_d;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; the combinational block above uses blocking ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         hold_full_q  <= 1'b0;
         shift_q      <= '0;
         idx_q        <= '0;
         gap_q        <= '0;
         dout_q       <= 1'b0;
         dout_vld_q   <= 1'b0;
         frame_done_q <= 1'b0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_full_q  <= hold_full_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         gap_q        <= gap_d;
         dout_q       <= dout_d;
         dout_vld_q   <= dout_vld_d;
         frame_done_q <= frame_done_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
      end
   end

   // NOTE: the hold data needs no reset; hold_full_q alone says whether it is meaningful.
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

endmodule

// File: tb/tb_seq_generator.sv
// Bench for seq_generator: one GAP=0/CNT_W=2 instance and one GAP=2 instance, with a
// scoreboard of expected serial bits popped by a monitor whenever dout_vld is high.
module tb_seq_generator;

   localparam int W = 18;

   typedef struct {
      logic       b;
      logic       last;
      logic [7:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst0, load_vld0, load_rdy0, dout0, dout_vld0, busy0, frame_done0;
   logic [W-1:0] load_data0;
   logic [1:0]   frame_cnt0;
   logic         rst1, load_vld1, load_rdy1, dout1, dout_vld1, busy1, frame_done1;
   logic [W-1:0] load_data1;
   logic [7:0]   frame_cnt1;

   seq_generator #(.WIDTH(W), .GAP(0), .CNT_W(2)) dut0 (
      .clk(clk), .rst(rst0), .load_vld(load_vld0), .load_data(load_data0),
      .load_rdy(load_rdy0), .dout(dout0), .dout_vld(dout_vld0), .busy(busy0),
      .frame_done(frame_done0), .frame_cnt(frame_cnt0)
   );

   seq_generator #(.WIDTH(W), .GAP(2), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst1), .load_vld(load_vld1), .load_data(load_data1),
      .load_rdy(load_rdy1), .dout(dout1), .dout_vld(dout_vld1), .busy(busy1),
      .frame_done(frame_done1), .frame_cnt(frame_cnt1)
   );

   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   exp_t q0[$];
   exp_t q1[$];
   int   cnt_m[2] = '{0, 0};
   logic [W-1:0] t6_words [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic get_dv(input int sel);
      return (sel == 0) ? dout_vld0 : dout_vld1;
   endfunction

   function automatic logic get_rdy(input int sel);
      return (sel == 0) ? load_rdy0 : load_rdy1;
   endfunction

   task automatic push_frame(input int sel, input logic [W-1:0] d);
      exp_t e;
      for (int i = W - 1; i >= 0; i--) begin
         e.b    = d[i];
         e.last = (i == 0);
         if (e.last) cnt_m[sel] = (cnt_m[sel] + 1) % ((sel == 0) ? 4 : 256);
         e.cnt  = 8'(cnt_m[sel]);
         if (sel == 0) q0.push_back(e);
         else          q1.push_back(e);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int sel, input logic [W-1:0] d);
      bit acc = 1'b0;
      int n   = 0;
      if (sel == 0) begin load_vld0 = 1'b1; load_data0 = d; end
      else          begin load_vld1 = 1'b1; load_data1 = d; end
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = get_rdy(sel);
         @(posedge clk);
         n++;
      end
      #1;
      if (sel == 0) load_vld0 = 1'b0;
      else          load_vld1 = 1'b0;
      check($sformatf("dut%0d accept 0x%05h", sel, d), 32'(acc), 32'd1);
      if (acc) push_frame(sel, d);
   endtask

   task automatic wait_level(input int sel, input logic lvl);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (get_dv(sel) !== lvl && n < 100);
      check($sformatf("dut%0d reach dout_vld=%0d", sel, lvl), 32'(get_dv(sel)), 32'(lvl));
   endtask

   // Starts at a falling edge where dout_vld==lvl; ends at the first one where it differs.
   task automatic count_run(input int sel, input logic lvl, output int n);
      n = 0;
      while (get_dv(sel) === lvl && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic reset_dut0();
      rst0 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      q0.delete();
      cnt_m[0] = 0;
      rst0 = 1'b0;
   endtask

   task automatic mon_check(input int sel);
      logic       dv, d, fd;
      logic [7:0] fc;
      exp_t       e;
      int         sz;
      dv = (sel == 0) ? dout_vld0   : dout_vld1;
      d  = (sel == 0) ? dout0       : dout1;
      fd = (sel == 0) ? frame_done0 : frame_done1;
      fc = (sel == 0) ? 8'(frame_cnt0) : frame_cnt1;
      sz = (sel == 0) ? q0.size()   : q1.size();
      if (dv === 1'b1) begin
         if (sz == 0) begin
            check($sformatf("dut%0d dout_vld with empty scoreboard", sel), 32'(dv), 32'd0);
         end else begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d dout", sel), 32'(d), 32'(e.b));
            check($sformatf("dut%0d frame_done", sel), 32'(fd), 32'(e.last));
            if (e.last) check($sformatf("dut%0d frame_cnt", sel), 32'(fc), 32'(e.cnt));
         end
      end else begin
         check($sformatf("dut%0d idle dout", sel), 32'(d), 32'd0);
         check($sformatf("dut%0d idle frame_done", sel), 32'(fd), 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_check(0);
         mon_check(1);
      end
   end

   initial begin
      int n;
      int k;
      rst0 = 1'b1; rst1 = 1'b1;
      load_vld0 = 1'b0; load_vld1 = 1'b0;
      load_data0 = '0; load_data1 = '0;
      t6_words[0] = 18'h00001;
      t6_words[1] = 18'h20000;
      t6_words[2] = 18'h0F0F0;
      t6_words[3] = 18'h3C3C3;
      t6_words[4] = 18'h12345;

      // T1: reset state
      repeat (3) @(posedge clk);
      #1;
      check("T1 dout", 32'(dout0), 32'd0);
      check("T1 dout_vld", 32'(dout_vld0), 32'd0);
      check("T1 frame_cnt", 32'(frame_cnt0), 32'd0);
      check("T1 load_rdy in reset", 32'(load_rdy0), 32'd0);
      check("T1 busy", 32'(busy0), 32'd0);
      check("T1 dut1 load_rdy in reset", 32'(load_rdy1), 32'd0);
      rst0 = 1'b0; rst1 = 1'b0;
      #1;
      check("T1 load_rdy after release", 32'(load_rdy0), 32'd1);
      check("T1 dut1 load_rdy after release", 32'(load_rdy1), 32'd1);
      mon_en = 1'b1;
      @(posedge clk); #1;

      // T2: single frame
      send(0, 18'b001110001101110000);
      wait_level(0, 1'b1);
      count_run(0, 1'b1, n);
      check("T2 dout_vld run", 32'(n), 32'd18);
      check("T2 frame_cnt", 32'(frame_cnt0), 32'd1);
      check("T2 busy after frame", 32'(busy0), 32'd0);
      @(posedge clk); #1;
      reset_dut0();

      // T3: back-to-back frames with no gap
      send(0, 18'h3FFFF);
      send(0, 18'h00001);
      wait_level(0, 1'b1);
      count_run(0, 1'b1, n);
      check("T3 contiguous dout_vld run", 32'(n), 32'd36);
      check("T3 frame_cnt", 32'(frame_cnt0), 32'd2);
      check("T3 busy after frames", 32'(busy0), 32'd0);

      // T4: two idle cycles between frames
      @(posedge clk); #1;
      send(1, 18'h2D5A3);
      send(1, 18'h1C3C3);
      check("T4 load_rdy while hold full", 32'(load_rdy1), 32'd0);
      check("T4 busy while hold full", 32'(busy1), 32'd1);
      wait_level(1, 1'b1);
      count_run(1, 1'b1, n);
      check("T4 first frame run", 32'(n), 32'd18);
      count_run(1, 1'b0, n);
      check("T4 gap length", 32'(n), 32'd2);
      count_run(1, 1'b1, n);
      check("T4 second frame run", 32'(n), 32'd18);
      check("T4 frame_cnt", 32'(frame_cnt1), 32'd2);

      // T5: reset in the middle of a frame with the hold register full
      @(posedge clk); #1;
      send(0, 18'h2AAAA);
      send(0, 18'h15555);
      wait_level(0, 1'b1);
      repeat (7) @(negedge clk);
      @(posedge clk); #1;
      rst0 = 1'b1;
      @(posedge clk); #1;
      q0.delete();
      cnt_m[0] = 0;
      @(negedge clk);
      check("T5 dout_vld after reset", 32'(dout_vld0), 32'd0);
      check("T5 frame_done after reset", 32'(frame_done0), 32'd0);
      check("T5 frame_cnt after reset", 32'(frame_cnt0), 32'd0);
      check("T5 load_rdy in reset", 32'(load_rdy0), 32'd0);
      @(posedge clk); #1;
      rst0 = 1'b0;
      #1;
      check("T5 hold empty after reset", 32'(load_rdy0), 32'd1);
      check("T5 busy after reset", 32'(busy0), 32'd0);
      k = 0;
      repeat (6) begin
         @(negedge clk);
         if (dout_vld0 !== 1'b0) k++;
      end
      check("T5 buffered word discarded", 32'(k), 32'd0);

      // T6: frame counter wraps with CNT_W=2
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) send(0, t6_words[i]);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((q0.size() != 0 || busy0 !== 1'b0) && k < 500);
      check("T6 drained", 32'(q0.size()), 32'd0);
      check("T6 final frame_cnt", 32'(frame_cnt0), 32'd1);

      repeat (4) @(negedge clk);
      check("dut0 scoreboard empty", 32'(q0.size()), 32'd0);
      check("dut1 scoreboard empty", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
